display_scheduler: RTL and testbench
====================================

Name: display_scheduler

Overview:
- Time-shares the 3-bit LED display between the traffic-light sequencer and the dice roller.
- Drives the display select and gates the dice roll enable from the user button.
- Holds a finished dice throw on screen for a fixed time, then returns the display to traffic.
- Guarantees traffic a minimum dwell between dice sessions; sits between button input, roll/traffic instances and the LED pins.

Parameters:
- MIN_TRAFFIC, 4: cycles traffic must be displayed before a dice session may start (>=1).
- HOLD_CYCLES, 8: cycles a finished throw stays displayed (>=1).
- MAX_ROLL, 32: maximum consecutive cycles roll_en may stay high (>=1).
- CNT_W, 8: counter width; must hold max(MIN_TRAFFIC, HOLD_CYCLES, MAX_ROLL).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- button  in  1  user request, synchronous to clk, level
- dice  in  3  current throw from dice roller
- rag  in  3  traffic lights {red, amber, green}
- roll_en  out  1  drives dice roller button input; high only in ROLL
- sel  out  1  1 = traffic shown, 0 = dice shown
- result  out  3  registered display value
- busy  out  1  high in ROLL or HOLD
- pending  out  1  dice request latched, not yet served

Behaviour:
- Reset (rst=0, asynchronous): state=TRAFFIC, sel=1, roll_en=0, busy=0, result=3'b000, pending=0, btn_q=0, all counters 0.
- Edge detect: btn_q <= button every cycle; press = button & ~btn_q. A held button is never a new press.
- Moore outputs decoded from the state register: sel=(state==TRAFFIC), roll_en=(state==ROLL), busy=~sel.
- result <= sel ? rag : dice every cycle. Result lags source and sel by exactly 1 cycle.
- TRAFFIC (00):
  - dwell counter increments, saturating at MIN_TRAFFIC.
  - If (press | pending) and dwell==MIN_TRAFFIC: go to ROLL, clear pending, clear roll counter.
  - Else if press: set pending.
- ROLL (01):
  - roll counter increments.
  - Exit to HOLD when button==0 or roll counter==MAX_ROLL-1, i.e. at most MAX_ROLL cycles in ROLL.
  - If entered via pending with button already low, ROLL lasts exactly 1 cycle.
  - On exit, load hold counter = HOLD_CYCLES-1.
- HOLD (10):
  - roll_en=0, so dice is frozen; sel=0.
  - Hold counter decrements; at 0, go to TRAFFIC and clear dwell to 0.
  - press during HOLD sets pending only. No re-roll until a full MIN_TRAFFIC dwell has elapsed.
- State 11 is illegal: go to TRAFFIC next cycle with outputs as in TRAFFIC.
- press in ROLL is impossible (button already high). Button release and MAX_ROLL reached in the same cycle gives a single transition to HOLD.
- pending is a single bit; multiple presses while pending are absorbed.
- Reset mid-session: immediate return to reset values; pending is lost.

Test Plan:
(defaults: MIN_TRAFFIC=4, HOLD_CYCLES=8, MAX_ROLL=32)
1. Reset then idle 10 cycles, rag stepping 100→110→001 → sel=1, roll_en=0, busy=0; result equals rag delayed by 1 cycle.
2. After ≥4 traffic cycles, button high 5 cycles then low, dice=3'b101 at release →
   - roll_en high for 5 cycles;
   - sel=0 for 5+8=13 cycles;
   - result=101 throughout HOLD (after 1-cycle lag);
   - then sel=1.
3. Button pulsed 1 cycle during HOLD → pending=1. Traffic is shown for exactly 4 cycles, then 1-cycle ROLL, then 8-cycle HOLD; pending=0 from ROLL entry.
4. Button held 50 cycles → roll_en high exactly 32 cycles, then HOLD 8 cycles, then TRAFFIC. Button still high at that point generates no new session.
5. Press 1 cycle after reset → pending=1; ROLL entered only when dwell reaches 4.
6. rst asserted low mid-ROLL, between clock edges → roll_en=0, sel=1, result=000 immediately, before the next clk edge; normal operation after release.

Source files
------------

// File: rtl/display_scheduler.sv
// display_scheduler: time-shares the 3-bit LED display between traffic lights and dice,
// gating dice rolls from the button and holding each throw before returning to traffic.
module display_scheduler #(
  parameter int MIN_TRAFFIC = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int MAX_ROLL    = 32,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  input  logic [2:0] dice,
  input  logic [2:0] rag,
  output logic       roll_en,
  output logic       sel,
  output logic [2:0] result,
  output logic       busy,
  output logic       pending
);
  typedef enum logic [1:0] {TRAFFIC = 2'b00, ROLL = 2'b01, HOLD = 2'b10, ILLEGAL = 2'b11} state_t;
  localparam logic [CNT_W-1:0] MIN_T     = CNT_W'(MIN_TRAFFIC);
  localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(MIN_TRAFFIC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ROLL_LAST = CNT_W'(MAX_ROLL - 1);
  state_t state, state_nxt;
  logic btn_q, press, go_roll, roll_done, pending_nxt;
  logic [CNT_W-1:0] dwell, roll_cnt, hold_cnt, dwell_nxt, roll_nxt, hold_nxt;
  assign press   = button & ~btn_q;
  assign sel     = (state != ROLL) && (state != HOLD);
  assign roll_en = state == ROLL;
  assign busy    = ~sel;
  // dwell counts the current cycle too, so traffic is shown exactly MIN_TRAFFIC cycles
  always_comb begin
    go_roll     = (state == TRAFFIC) && (press || pending) && (dwell >= MIN_LAST);
    roll_done   = !button || (roll_cnt == ROLL_LAST);
    state_nxt   = state == TRAFFIC ? (go_roll ? ROLL : TRAFFIC)
                : state == ROLL    ? (roll_done ? HOLD : ROLL)
                : state == HOLD    ? (hold_cnt == '0 ? TRAFFIC : HOLD)
                : TRAFFIC;
    dwell_nxt   = state != TRAFFIC ? '0 : dwell == MIN_T ? dwell : dwell + 1'b1;
    roll_nxt    = state == ROLL ? roll_cnt + 1'b1 : '0;
    hold_nxt    = state == ROLL ? HOLD_LAST
                : (state == HOLD && hold_cnt != '0) ? hold_cnt - 1'b1 : '0;
    pending_nxt = go_roll ? 1'b0 : pending | press;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= TRAFFIC;
      btn_q    <= 1'b0;
      pending  <= 1'b0;
      result   <= 3'b000;
      dwell    <= '0;
      roll_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      btn_q    <= button;
      pending  <= pending_nxt;
      result   <= sel ? rag : dice;
      dwell    <= dwell_nxt;
      roll_cnt <= roll_nxt;
      hold_cnt <= hold_nxt;
    end
  end
endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed stimulus against a cycle-level behavioural model of the
// display scheduler, plus hand-computed window counts for each scenario.
module tb_display_scheduler;
  localparam int MT = 4, HC = 8, MR = 32;
  localparam int M_TRAFFIC = 0, M_ROLL = 1, M_HOLD = 2;
  logic clk = 1'b0, rst = 1'b0, button = 1'b0;
  logic [2:0] dice = 3'b000, rag = 3'b000;
  logic roll_en, sel, busy, pending;
  logic [2:0] result;
  int checks = 0, failures = 0;
  int re_cnt = 0, sel0_cnt = 0, hres_cnt = 0;
  int m_mode, m_shown, m_rolled, m_hold;
  logic m_pend, m_btn_q, m_press;
  logic [2:0] m_res;
  logic [2:0] pat [3];

  display_scheduler dut (
    .clk(clk), .rst(rst), .button(button), .dice(dice), .rag(rag),
    .roll_en(roll_en), .sel(sel), .result(result), .busy(busy), .pending(pending)
  );

  always #5 clk = ~clk;

  // model: m_shown/m_rolled count cycles spent in the mode including the current one
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = M_TRAFFIC; m_shown = 0; m_rolled = 0; m_hold = 0;
      m_pend = 1'b0; m_btn_q = 1'b0; m_res = 3'b000;
    end else begin
      m_press = button && !m_btn_q;
      m_btn_q = button;
      m_res = (m_mode == M_ROLL || m_mode == M_HOLD) ? dice : rag;
      if (m_mode == M_TRAFFIC) begin
        m_shown = (m_shown + 1 > MT) ? MT : m_shown + 1;
        if ((m_press || m_pend) && m_shown == MT) begin
          m_mode = M_ROLL; m_pend = 1'b0; m_rolled = 0;
        end else if (m_press) m_pend = 1'b1;
      end else if (m_mode == M_ROLL) begin
        m_rolled++;
        if (!button || m_rolled == MR) begin m_mode = M_HOLD; m_hold = HC; end
      end else begin
        if (m_press) m_pend = 1'b1;
        m_hold--;
        if (m_hold == 0) begin m_mode = M_TRAFFIC; m_shown = 0; end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic e_sel;
    e_sel = !(m_mode == M_ROLL || m_mode == M_HOLD);
    chk("sel", 32'(sel), 32'(e_sel));
    chk("roll_en", 32'(roll_en), 32'(m_mode == M_ROLL));
    chk("busy", 32'(busy), 32'(!e_sel));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("result", 32'(result), 32'(m_res));
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
    compare_all();
    re_cnt   += int'(roll_en);
    sel0_cnt += int'(!sel);
    hres_cnt += int'(busy && !roll_en && result == 3'b101);
  endtask

  initial begin
    int n, b_re, b_s0, b_hr;
    pat[0] = 3'b100; pat[1] = 3'b110; pat[2] = 3'b001;
    repeat (2) cyc();
    chk("reset_sel", 32'(sel), 32'd1);
    chk("reset_roll_en", 32'(roll_en), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_pending", 32'(pending), 32'd0);
    rst = 1'b1;
    // 1: idle traffic, result follows rag one cycle late
    for (int i = 0; i < 10; i++) begin rag = pat[i % 3]; cyc(); end
    chk("idle_result", 32'(result), 32'(3'b100));
    chk("idle_sel", 32'(sel), 32'd1);
    // 2: 5-cycle press, throw 101 held for 8 cycles
    b_re = re_cnt; b_s0 = sel0_cnt; b_hr = hres_cnt;
    dice = 3'b101; button = 1'b1;
    repeat (5) cyc();
    button = 1'b0;
    repeat (20) cyc();
    chk("t2_roll_cycles", 32'(re_cnt - b_re), 32'd5);
    chk("t2_sel0_cycles", 32'(sel0_cnt - b_s0), 32'd13);
    chk("t2_hold_result", 32'(hres_cnt - b_hr), 32'd8);
    chk("t2_back_to_traffic", 32'(sel), 32'd1);
    // 3: pulse during HOLD is deferred until a full traffic dwell
    button = 1'b1; cyc(); cyc(); button = 1'b0;
    repeat (2) cyc();
    chk("t3_in_hold", 32'(busy && !roll_en), 32'd1);
    button = 1'b1; cyc(); button = 1'b0;
    chk("t3_pending", 32'(pending), 32'd1);
    n = 0; while (!sel && n < 20) begin cyc(); n++; end
    n = 0; while (sel && n < 20) begin cyc(); n++; end
    chk("t3_traffic_dwell", 32'(n), 32'd4);
    chk("t3_pending_cleared", 32'(pending), 32'd0);
    n = 0; while (roll_en && n < 40) begin cyc(); n++; end
    chk("t3_roll_len", 32'(n), 32'd1);
    n = 0; while (busy && n < 20) begin cyc(); n++; end
    chk("t3_hold_len", 32'(n), 32'd8);
    // 4: button held 50 cycles, roll capped at MAX_ROLL, no re-trigger
    repeat (6) cyc();
    b_re = re_cnt; b_s0 = sel0_cnt;
    button = 1'b1;
    repeat (50) cyc();
    button = 1'b0;
    repeat (5) cyc();
    chk("t4_roll_cap", 32'(re_cnt - b_re), 32'd32);
    chk("t4_sel0_cycles", 32'(sel0_cnt - b_s0), 32'd40);
    chk("t4_no_pending", 32'(pending), 32'd0);
    // 5: press right after reset waits for the dwell
    rst = 1'b0; cyc(); rst = 1'b1;
    cyc();
    button = 1'b1; cyc(); button = 1'b0;
    chk("t5_pending", 32'(pending), 32'd1);
    n = 0; while (!roll_en && n < 20) begin cyc(); n++; end
    chk("t5_wait", 32'(n), 32'd2);
    // 6: asynchronous reset mid-ROLL
    repeat (15) cyc();
    button = 1'b1;
    repeat (3) cyc();
    chk("t6_in_roll", 32'(roll_en), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("t6_async_roll_en", 32'(roll_en), 32'd0);
    chk("t6_async_sel", 32'(sel), 32'd1);
    chk("t6_async_result", 32'(result), 32'd0);
    chk("t6_async_pending", 32'(pending), 32'd0);
    cyc();
    rst = 1'b1;
    cyc();
    chk("t6_repress_pending", 32'(pending), 32'd1);
    repeat (4) cyc();
    button = 1'b0;
    repeat (30) cyc();
    chk("t6_final_sel", 32'(sel), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
